ibex_instr_bus_arb: RTL

Two-requester arbiter for the core instruction bus. It shares one instruction memory port between the IF-stage fetch path (port 0) and an auxiliary instruction requester (port 1), such as a debug-module or trace-fetch master. It sits between those requesters and the top-level `instr_req_o`/`instr_gnt_i`/`instr_rvalid_i` interface. It adds zero cycles of latency, keeps the selected address stable until it is granted, and routes in-order responses back to their originator through an outstanding-owner FIFO.

---
 rtl/ibex_instr_bus_arb.sv | 108 ++++++++++
 1 files changed

// File: rtl/ibex_instr_bus_arb.sv
// Two-port instruction bus arbiter with zero-latency request/response paths and an owner FIFO.
// Define IBEX_IBUS_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module ibex_instr_bus_arb #(
    parameter int MemDataWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              host_req_i,
    input  logic [1:0][31:0]        host_addr_i,
    output logic [1:0]              host_gnt_o,
    output logic [1:0]              host_rvalid_o,
    output logic [MemDataWidth-1:0] host_rdata_o,
    output logic                    host_err_o,
    output logic                    bus_req_o,
    output logic [31:0]             bus_addr_o,
    input  logic                    bus_gnt_i,
    input  logic                    bus_rvalid_i,
    input  logic [MemDataWidth-1:0] bus_rdata_i,
    input  logic                    bus_err_i,
    output logic [2:0]              outstanding_o,
    output logic                    unexp_rsp_o,
    output logic                    busy_o
);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {IDLE, LOCK} state_e;

    state_e                    state_q;
    logic                      lock_port_q;
    logic                      sel, tie_sel, cap_ok, push, pop, head;
    logic [MaxOutstanding-1:0] owner_q;
    logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [2:0]                count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

`ifdef IBEX_IBUS_ARB_RR_EN
    // Last granted port; reset to 1 so the first tie goes to port 0.
    logic last_q;
    assign tie_sel = ~last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   last_q <= 1'b1;
        else if (push) last_q <= sel;
    end
`else
    assign tie_sel = 1'b0;
`endif

    always_comb begin
        sel = 1'b0;
        if (state_q == LOCK)          sel = lock_port_q;
        else if (host_req_i == 2'b10) sel = 1'b1;
        else if (host_req_i == 2'b11) sel = tie_sel;
    end

    // Gate on the registered count: a same-cycle pop does not reopen it.
    assign cap_ok        = count_q < 3'(MaxOutstanding);
    assign bus_req_o     = host_req_i[sel] & cap_ok;
    assign bus_addr_o    = host_addr_i[sel];
    assign push          = bus_req_o & bus_gnt_i;
    assign host_gnt_o    = push ? (sel ? 2'b10 : 2'b01) : 2'b00;

    assign pop           = bus_rvalid_i & (count_q != 3'd0);
    assign head          = owner_q[rd_ptr_q];
    assign host_rvalid_o = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
    assign host_rdata_o  = bus_rdata_i;
    assign host_err_o    = bus_err_i;
    assign unexp_rsp_o   = bus_rvalid_i & (count_q == 3'd0);
    assign outstanding_o = count_q;
    assign busy_o        = (|host_req_i) | (count_q != 3'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lock_port_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus_req_o && !bus_gnt_i) begin
                    state_q     <= LOCK;
                    lock_port_q <= sel;
                end
                LOCK: if (bus_gnt_i || !host_req_i[lock_port_q]) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= sel;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + 3'(push) - 3'(pop);
        end
    end

endmodule
